// File: rtl/dpi_array_marshal_if.sv
`default_nettype none
// ============================================================================
// Module      : dpi_array_marshal_if
// Description : Request, host tx/rx and response channels of the DPI array
//               marshalling stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface dpi_array_marshal_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic           req_valid_i;
  logic           req_ready_o;
  logic [7:0]     req_func_id_i;
  logic           req_dir_i;
  logic [15:0]    req_n_i;
  logic [N*W-1:0] req_data_i;
  logic           tx_valid_o;
  logic           tx_ready_i;
  logic [W-1:0]   tx_data_o;
  logic           tx_last_o;
  logic           rx_valid_i;
  logic           rx_ready_o;
  logic [W-1:0]   rx_data_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [W-1:0]   rsp_ret_o;
  logic [N*W-1:0] rsp_data_o;
  logic           rsp_clamp_o;

  // Marshalling stage side
  modport slave (
    input  req_valid_i, req_func_id_i, req_dir_i, req_n_i, req_data_i,
           tx_ready_i, rx_valid_i, rx_data_i, rsp_ready_i,
    output req_ready_o, tx_valid_o, tx_data_o, tx_last_o, rx_ready_o,
           rsp_valid_o, rsp_ret_o, rsp_data_o, rsp_clamp_o
  );

  // Call site and host side
  modport master (
    output req_valid_i, req_func_id_i, req_dir_i, req_n_i, req_data_i,
           tx_ready_i, rx_valid_i, rx_data_i, rsp_ready_i,
    input  req_ready_o, tx_valid_o, tx_data_o, tx_last_o, rx_ready_o,
           rsp_valid_o, rsp_ret_o, rsp_data_o, rsp_clamp_o
  );
endinterface
`default_nettype wire

// File: rtl/dpi_array_marshal.sv
`default_nettype none
// ============================================================================
// Module      : dpi_array_marshal
// Description : Serialises a DPI call header and array onto a 32-bit host
//               channel and collects output elements plus return value.
// Revision    : 1.0 - initial release
// ============================================================================
module dpi_array_marshal #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dpi_array_marshal_if.slave  bus
);
  localparam int IW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEND = 3'd2,
    S_RECV = 3'd3,
    S_RET  = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_func;
  logic           r_dir;
  logic           r_clamp;
  logic [IW-1:0]  r_neff;
  logic [IW-1:0]  r_idx;
  logic [N*W-1:0] r_arr;
  logic [W-1:0]   r_ret;

  logic [IW-1:0]  w_idx_inc;
  logic           w_last_elem;
  logic           w_clamp_req;
  logic [IW-1:0]  w_neff_req;
  logic [W-1:0]   w_elem;

  assign w_idx_inc   = r_idx + IW'(1);
  assign w_last_elem = (w_idx_inc == r_neff);
  assign w_clamp_req = (bus.req_n_i > 16'(N));
  assign w_neff_req  = w_clamp_req ? IW'(N) : bus.req_n_i[IW-1:0];

  always_comb begin
    w_elem = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IW'(i)) w_elem = r_arr[i*W +: W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Outputs decode from state and latched registers only
  always_comb begin
    w_state_nxt     = r_state;
    bus.req_ready_o = 1'b0;
    bus.tx_valid_o  = 1'b0;
    bus.tx_data_o   = '0;
    bus.tx_last_o   = 1'b0;
    bus.rx_ready_o  = 1'b0;
    bus.rsp_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = {r_func, r_dir, 7'b0, 16'(r_neff)};
        bus.tx_last_o  = r_dir || (r_neff == '0);
        if (bus.tx_ready_i) begin
          if (r_neff == '0) w_state_nxt = S_RET;
          else if (r_dir)   w_state_nxt = S_RECV;
          else              w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = w_elem;
        bus.tx_last_o  = w_last_elem;
        if (bus.tx_ready_i && w_last_elem) w_state_nxt = S_RET;
      end
      S_RECV: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i && w_last_elem) w_state_nxt = S_RET;
      end
      S_RET: begin
        bus.rx_ready_o = 1'b1;
        if (bus.rx_valid_i) w_state_nxt = S_RSP;
      end
      S_RSP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_func  <= '0;
      r_dir   <= 1'b0;
      r_clamp <= 1'b0;
      r_neff  <= '0;
      r_idx   <= '0;
      r_arr   <= '0;
      r_ret   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_func  <= bus.req_func_id_i;
            r_dir   <= bus.req_dir_i;
            r_arr   <= bus.req_data_i;
            r_neff  <= w_neff_req;
            r_clamp <= w_clamp_req;
            r_idx   <= '0;
          end
        end
        S_SEND: begin
          if (bus.tx_ready_i) r_idx <= w_idx_inc;
        end
        S_RECV: begin
          if (bus.rx_valid_i) begin
            for (int i = 0; i < N; i++) begin
              if (r_idx == IW'(i)) r_arr[i*W +: W] <= bus.rx_data_i;
            end
            r_idx <= w_idx_inc;
          end
        end
        S_RET: begin
          if (bus.rx_valid_i) r_ret <= bus.rx_data_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_ret_o   = r_ret;
  assign bus.rsp_data_o  = r_arr;
  assign bus.rsp_clamp_o = r_clamp;
endmodule
`default_nettype wire

// File: doc/dpi_array_marshal.md
# dpi_array_marshal

Hardware-side marshalling stage for DPI calls carrying one fixed-size unpacked `bit [31:0] [N]` array argument. It sits directly downstream of a call site that has already packed the array into a flat `N*32`-bit vector. It serialises a call header and input-array elements onto a 32-bit host channel, then collects the host's reply words (output-array elements plus the `int` return value). The result is returned to the call site as one packed response.

## Interface
Parameters:
- N, 4, number of array elements; 1..255
- W, 32, element and channel word width; fixed at 32

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  call request valid
- req_ready_o  output  1  request accepted when valid&&ready
- req_func_id_i  input  8  DPI function identifier
- req_dir_i  input  1  0 = array is an input argument (host reads it), 1 = array is an output argument (host writes it)
- req_n_i  input  16  element count (`n_elements`)
- req_data_i  input  N*32  packed array; element i is at bits [i*32+:32]
- tx_valid_o  output  1  host-bound word valid
- tx_ready_i  input  1  host accepts word
- tx_data_o  output  32  host-bound word
- tx_last_o  output  1  final word of this call's transmission
- rx_valid_i  input  1  host reply word valid
- rx_ready_o  output  1  reply word accepted
- rx_data_i  input  32  reply word
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_ret_o  output  32  DPI return value
- rsp_data_o  output  N*32  packed array after the call
- rsp_clamp_o  output  1  req_n_i exceeded N and was clamped

## Operation
- FSM states: IDLE, HDR, SEND, RECV, RET, RSP. Reset state is IDLE.
- IDLE:
  - req_ready_o=1.
  - On handshake, latch func_id, dir and req_data.
  - Latch n_eff = min(req_n_i, N) and set clamp = (req_n_i > N).
  - Go to HDR.
- HDR:
  - tx_data_o = {func_id[7:0], dir, 7'b0, n_eff[15:0]}.
  - tx_last_o = (dir==1 || n_eff==0).
  - On tx handshake: if dir==0 and n_eff>0, go to SEND; else if dir==1 and n_eff>0, go to RECV; else go to RET.
- SEND:
  - tx_data_o = element idx of the latched array, idx starting at 0.
  - tx_last_o = (idx == n_eff-1).
  - Advance idx on each handshake; after the last handshake go to RET.
- RECV:
  - rx_ready_o=1.
  - Each accepted word overwrites element idx of the latched array.
  - After n_eff words, go to RET.
- RET:
  - rx_ready_o=1.
  - The accepted word is latched into ret; go to RSP.
- RSP:
  - rsp_valid_o=1; rsp_data_o is the latched array and rsp_clamp_o is the latched clamp flag.
  - On rsp_ready_i, go to IDLE.
- Array contents:
  - Elements at index ≥ n_eff keep their request values.
  - For dir==0, rsp_data_o equals req_data_i.
- Handshake gating: tx_valid_o is asserted only in HDR and SEND. rx_ready_o is 0 outside RECV and RET, so early host words stall.
- Counter: idx is $clog2(N+1) bits wide and never wraps, because n_eff ≤ N.

## Timing
- Reset values: req_ready_o=1; tx_valid_o, tx_last_o, rx_ready_o, rsp_valid_o, rsp_clamp_o = 0; tx_data_o, rsp_ret_o, rsp_data_o = 0.
- Asynchronous reset mid-call aborts immediately: no partial response and no further tx words. Data the host has already consumed is not retracted.
- Only one call is in flight. req_ready_o=0 from the cycle after acceptance until the cycle after the rsp handshake.
- All outputs are registered or decoded from state only, with no combinational input-to-output path. Exception: tx_valid_o and tx_data_o must stay stable while tx_ready_i=0.
- Best-case latency with tx_ready_i and rx_valid_i held high, where cycle 0 is the request handshake:
  - dir=0, n_eff=k: header in cycle 1, data in cycles 2..k+1, ret accepted in cycle k+2, rsp_valid_o in cycle k+3.
  - dir=1, n_eff=k: header in cycle 1, rx words in cycles 2..k+1, ret in cycle k+2, rsp_valid_o in cycle k+3.
- Back-to-back calls: the next request can be accepted in the cycle after the rsp handshake.

## Test plan
- **Input array.** Request dir=0, n=4, func 0x02, data 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0.
  - tx words: 0x0200_0004, then 0x9ABCDEF0, 0x12345678, 0xCAFEBABE, 0xDEADBEEF, with tx_last_o on the last.
  - Host replies 0x1234; rsp_ret_o=0x1234 and rsp_data_o is unchanged.
- **Output array.** Request dir=1, n=4, func 0x01.
  - tx: single header 0x0180_0004 with tx_last_o=1.
  - Host sends 1, 2, 3, 4, then ret 4; rsp_data_o = {4,3,2,1} (element 0 in the LSBs) and rsp_ret_o=4.
- **Partial and clamp.** dir=1, n=2 with preload {A,B,C,D}: host words X, Y produce {A,B,Y,X}. Separately, n=9 produces header count 4, exactly 4 rx words, and rsp_clamp_o=1.
- **Backpressure.** tx_ready_i toggled at random and rx_valid_i delayed: tx_data_o is held stable while stalled, word order is preserved, rx_ready_o=0 in HDR/SEND, and the result is identical to the first scenario.
- **Zero count and reset.** n=0 dir=0: header only, with tx_last_o=1, then ret. Reset asserted in SEND after 2 words: all outputs return to their reset values, and the next call completes normally.
